// File: rtl/fb_blitter.sv
// rtl/fb_blitter.sv - framebuffer blitter: scaled copy from main RAM, or clear
module fb_blitter #(
  parameter int SRC_BASE  = 'h100,
  parameter int SRC_COLS  = 8,
  parameter int SRC_ROWS  = 32,
  parameter int SCALE     = 2,
  parameter int FB_BASE   = 0,
  parameter int FB_STRIDE = 16,
  parameter int FB_AW     = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [11:0]      main_ram_read_address,
  input  logic [7:0]       main_ram_out,
  output logic [FB_AW-1:0] fb_write_address,
  output logic             fb_write_enable,
  output logic [7:0]       fb_ram_in
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, CLEAR} state_t;

  // Copy walks source coordinates; clear reuses the same counters as
  // destination coordinates, hence the two sets of limits.
  localparam logic [15:0] LAST_COL  = 16'(SRC_COLS - 1);
  localparam logic [15:0] LAST_ROW  = 16'(SRC_ROWS - 1);
  localparam logic [15:0] LAST_DCOL = 16'(SRC_COLS * SCALE - 1);
  localparam logic [15:0] LAST_DROW = 16'(SRC_ROWS * SCALE - 1);
  localparam logic [1:0]  LAST_SUB  = 2'(SCALE * SCALE - 1);

  state_t             state_q, state_d;
  logic [15:0]        row_q, row_d;
  logic [15:0]        col_q, col_d;
  logic [1:0]         sub_q, sub_d;
  logic [7:0]         byte_q, byte_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [11:0]        rd_addr_q, rd_addr_d;
  logic [FB_AW-1:0]   wr_addr_q, wr_addr_d;
  logic               wr_en_q, wr_en_d;
  logic [7:0]         wr_data_q, wr_data_d;

  logic [1:0]         beat_sub;
  logic [7:0]         beat_byte;
  logic [15:0]        beat_row;
  logic [15:0]        beat_col;
  logic [FB_AW-1:0]   beat_addr;
  logic [7:0]         beat_data;

  // Address arithmetic deliberately truncates to the port width.
  function automatic logic [11:0] src_addr(input logic [15:0] r, input logic [15:0] c);
    return 12'(SRC_BASE + SRC_COLS * int'(r) + int'(c));
  endfunction

  function automatic logic [FB_AW-1:0] dst_addr(input logic [15:0] r, input logic [15:0] c);
    return FB_AW'(FB_BASE + FB_STRIDE * int'(r) + int'(c));
  endfunction

  // Doubles each pixel of a nibble horizontally; MSB is the leftmost pixel.
  function automatic logic [7:0] dbl(input logic [3:0] n);
    return {n[3], n[3], n[2], n[2], n[1], n[1], n[0], n[0]};
  endfunction

  // Address and data of the write beat to present next: beat 0 when leaving
  // WAIT (byte straight from RAM), otherwise the beat after the current one.
  always_comb begin
    beat_sub  = (state_q == WAIT) ? 2'd0 : sub_q + 2'd1;
    beat_byte = (state_q == WAIT) ? main_ram_out : byte_q;
    beat_row  = (SCALE == 2) ? {row_q[14:0], beat_sub[1]} : row_q;
    beat_col  = (SCALE == 2) ? {col_q[14:0], beat_sub[0]} : col_q;
    beat_addr = dst_addr(beat_row, beat_col);
    if (SCALE == 2) begin
      beat_data = beat_sub[0] ? dbl(beat_byte[3:0]) : dbl(beat_byte[7:4]);
    end else begin
      beat_data = beat_byte;
    end
  end

  // Next-state and next-output logic; every output is computed one cycle
  // ahead so that the ports come straight from flops.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    sub_d     = sub_q;
    byte_d    = byte_q;
    done_d    = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          row_d = '0;
          col_d = '0;
          sub_d = '0;
          if (mode) begin
            state_d   = CLEAR;
            wr_en_d   = 1'b1;
            wr_addr_d = dst_addr('0, '0);
            wr_data_d = 8'h00;
          end else begin
            state_d   = READ;
            rd_addr_d = src_addr('0, '0);
          end
        end
      end
      READ: begin
        state_d = WAIT;
      end
      WAIT: begin
        state_d   = WRITE;
        byte_d    = main_ram_out;
        sub_d     = '0;
        wr_en_d   = 1'b1;
        wr_addr_d = beat_addr;
        wr_data_d = beat_data;
      end
      WRITE: begin
        if (sub_q == LAST_SUB) begin
          if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = row_q + 16'd1;
          end else begin
            col_d = col_q + 16'd1;
          end
          if (col_q == LAST_COL && row_q == LAST_ROW) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d   = READ;
            rd_addr_d = src_addr(row_d, col_d);
          end
        end else begin
          sub_d     = sub_q + 2'd1;
          wr_en_d   = 1'b1;
          wr_addr_d = beat_addr;
          wr_data_d = beat_data;
        end
      end
      CLEAR: begin
        if (col_q == LAST_DCOL && row_q == LAST_DROW) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          if (col_q == LAST_DCOL) begin
            col_d = '0;
            row_d = row_q + 16'd1;
          end else begin
            col_d = col_q + 16'd1;
          end
          wr_en_d   = 1'b1;
          wr_addr_d = dst_addr(row_d, col_d);
          wr_data_d = 8'h00;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any operation without done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      sub_q     <= '0;
      byte_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      sub_q     <= sub_d;
      byte_q    <= byte_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy                  = busy_q;
  assign done                  = done_q;
  assign main_ram_read_address = rd_addr_q;
  assign fb_write_address      = wr_addr_q;
  assign fb_write_enable       = wr_en_q;
  assign fb_ram_in             = wr_data_q;

endmodule
